led_pattern_rx: RTL

//  Receiver for the single-pin serial blink protocol the LED output drives: samples one input pin,

---
 rtl/led_pattern_rx_pkg.sv | 19 +
 rtl/led_pattern_rx_pin_sync.sv | 18 +
 rtl/led_pattern_rx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/led_pattern_rx_pkg.sv
// Shared definitions for the single-pin blink protocol (receiver and LED transmitter agree on these).
package led_pattern_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  localparam logic        IDLE_LVL           = 1'b0;
  localparam logic        START_LVL          = 1'b1;
  localparam int unsigned DEFAULT_BIT_CYCLES = 2097152;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/led_pattern_rx_pin_sync.sv
// Two-flop synchronizer for the asynchronous serial pin; reset value 0.
module pin_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/led_pattern_rx.sv
// Serial blink-protocol receiver: start 1, WORD_W data bits MSB first, stop 0, BIT_CYCLES clocks per bit.
// Optional LED_PATTERN_RX_MAJORITY_EN: 2-of-3 vote around mid-bit instead of a single sample.
module led_pattern_rx
  import led_pattern_rx_pkg::*;
#(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned BIT_CYCLES = DEFAULT_BIT_CYCLES,
  parameter int unsigned CNT_W      = 22
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              PIN_IN,
  output logic [WORD_W-1:0] DATA,
  output logic              VALID,
  output logic              FRAME_ERR,
  output logic              BUSY
);

  localparam int unsigned      IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] TMR_LAST = CNT_W'(BIT_CYCLES - 1);

  logic              s;
  logic              sample;
  logic              bit_val;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  tmr_q, tmr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;

  pin_sync u_pin_sync (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .d_i    (PIN_IN),
    .q_o    (s)
  );

`ifdef LED_PATTERN_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] TMR_V0     = CNT_W'(BIT_CYCLES / 2 - 2);
  localparam logic [CNT_W-1:0] TMR_V1     = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] TMR_SAMPLE = CNT_W'(BIT_CYCLES / 2);

  logic [1:0] vote_q;

  // Two earlier samples are held so the third (live) one completes the vote at the decision point.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vote_q <= '0;
    end else begin
      if (tmr_q == TMR_V0) vote_q[0] <= s;
      if (tmr_q == TMR_V1) vote_q[1] <= s;
    end
  end

  assign bit_val = maj3(vote_q[0], vote_q[1], s);
`else
  localparam logic [CNT_W-1:0] TMR_SAMPLE = CNT_W'(BIT_CYCLES / 2 - 1);

  assign bit_val = s;
`endif

  assign sample = (tmr_q == TMR_SAMPLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = (tmr_q == TMR_LAST) ? '0 : tmr_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (s == START_LVL) state_d = ST_START;
      end
      ST_START: begin
        if (sample) begin
          if (bit_val == START_LVL) begin
            state_d = ST_DATA;
            idx_d   = IDX_W'(WORD_W - 1);
          end else begin
            state_d = ST_IDLE;
            tmr_d   = '0;
          end
        end
      end
      ST_DATA: begin
        if (sample) begin
          shift_d = (shift_q << 1) | WORD_W'(bit_val);
          if (idx_q == '0) state_d = ST_STOP;
          else             idx_d   = idx_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (sample) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
          if (bit_val == IDLE_LVL) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign DATA      = data_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = ferr_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule
